// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/data/grant bundle between requesters and the 8:1 round-robin arbiter
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] I;
   logic [7:0] gnt;
   logic [2:0] S;
   logic       gnt_valid;
   logic       Y;

   // requester side: raises requests and presents data, observes grant and muxed output
   modport master (
      output req,
      output I,
      input  gnt,
      input  S,
      input  gnt_valid,
      input  Y
   );

   // arbiter side
   modport slave (
      input  req,
      input  I,
      output gnt,
      output S,
      output gnt_valid,
      output Y
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter driving an 8:1 single-bit mux; ARB_TIMEOUT_EN adds a MAX_HOLD grant limit
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mux8_rr_arbiter_if.slave        bus
);

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
      $error("MAX_HOLD must be in 1..15");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q,   ptr_d;
   logic [7:0] gnt_q,   gnt_d;
   logic [2:0] s_q,     s_d;
   logic       valid_q, valid_d;

`ifdef ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
   logic [3:0] hold_q, hold_d;
`endif

   logic [2:0] win_idle;
   logic [2:0] win_next;
   logic       others;

   // First requester at or after 'start' going upward modulo 8; scanning offsets
   // from high to low lets the nearest one overwrite the result last.
   function automatic logic [2:0] pick_from(input logic [7:0] r, input logic [2:0] start);
      logic [2:0] idx;
      pick_from = start;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (r[idx]) pick_from = idx;
      end
   endfunction

   assign win_idle = pick_from(bus.req, ptr_q);
   assign win_next = pick_from(bus.req, s_q + 3'd1);
   // Any requester other than the current owner; gnt_q is one-hot on S in GRANT.
   assign others   = |(bus.req & ~gnt_q);

   // State, pointer and grant registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         gnt_q   <= 8'h00;
         s_q     <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         valid_q <= valid_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Consecutive-cycle count of the current grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= 4'd0;
      else        hold_q <= hold_d;
   end
`endif

   // Next-state: pick a winner from idle, hold or hand over without a bubble in GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      s_d     = s_q;
      valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            gnt_d   = 8'h00;
            valid_d = 1'b0;
            if (|bus.req) begin
               gnt_d   = 8'h01 << win_idle;
               s_d     = win_idle;
               valid_d = 1'b1;
               state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
               hold_d  = 4'd0;
`endif
            end
         end
         GRANT: begin
            if (!bus.req[s_q]) begin
               ptr_d = s_q + 3'd1;
               if (others) begin
                  gnt_d = 8'h01 << win_next;
                  s_d   = win_next;
`ifdef ARB_TIMEOUT_EN
                  hold_d = 4'd0;
`endif
               end else begin
                  gnt_d   = 8'h00;
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_q == HOLD_LAST) begin
               // Owner has used its quota: rotate if anyone else waits, else restart the count.
               hold_d = 4'd0;
               if (others) begin
                  ptr_d = s_q + 3'd1;
                  gnt_d = 8'h01 << win_next;
                  s_d   = win_next;
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.S         = s_q;
   assign bus.gnt_valid = valid_q;
   assign bus.Y         = valid_q & bus.I[s_q];

endmodule
